mac_result_unpacker: RTL and testbench
======================================

# mac_result_unpacker

Drain-side companion to the packed-lane DSP MAC. It captures one packed accumulator word (two 24-bit lanes in 8x8 mode, four 16-bit lanes in 1x8 mode), unpacks the lanes, and sign-extends each to a common signed output width. An optional ReLU can be applied per lane. Lanes leave one per beat on a valid/ready stream toward the requantization and write-back path. It sits between the PE array's accumulator registers and the output buffer, and frees the MAC to start the next reduction as soon as the word is captured.

## Interface
- `ACC_WIDTH_88`, default 24: lane width in mode 0.
- `ACC_WIDTH_18`, default 16: lane width in mode 1.
- `PACKED_WIDTH`, default 64: packed accumulator word width. Must be ≥ 4·`ACC_WIDTH_18` and ≥ 2·`ACC_WIDTH_88`.
- `OUT_WIDTH`, default 24: signed output lane width. Must be ≥ `ACC_WIDTH_88`.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `load`, in, 1: capture strobe for `packed_i`, `mode` and `relu`.
- `load_ready`, out, 1: a capture occurs on `load && load_ready`.
- `mode`, in, 1: 0 = 8x8 (2 lanes of 24 bits), 1 = 1x8 (4 lanes of 16 bits).
- `relu`, in, 1: when 1, negative lanes are output as 0.
- `packed_i`, in, `PACKED_WIDTH`: packed accumulator word.
- `m_valid`, out, 1: output beat valid.
- `m_ready`, in, 1: downstream accept.
- `m_data`, out, `OUT_WIDTH`: signed lane value.
- `m_lane`, out, 2: lane index of the current beat.
- `m_last`, out, 1: marks the final lane of the word.
- `busy`, out, 1: high while a captured word is still draining.

## Operation
- Lane layout:
  - Mode 0: lane k = `packed_i[24k +: 24]` for k = 0..1. Bits 63:48 are ignored.
  - Mode 1: lane k = `packed_i[16k +: 16]` for k = 0..3.
- Each lane is sign-extended from its MSB to `OUT_WIDTH`. No other arithmetic is applied and no saturation is needed.
- ReLU: if `relu` was captured as 1 and the lane MSB is 1, `m_data` = 0. Otherwise `m_data` is the sign-extended lane.
- FSM has two states, IDLE and EMIT. A registered `lane_cnt` (2 bits) selects the lane.
  - IDLE → EMIT on `load && load_ready`. The capture registers the word, mode and relu, and sets `lane_cnt` = 0.
  - In EMIT, each handshake (`m_valid && m_ready`) advances `lane_cnt`.
  - On the handshake of the last lane (`lane_cnt` = 1 in mode 0, 3 in mode 1): go to IDLE, unless `load` is high in the same cycle. In that case capture the new word, reset `lane_cnt` to 0 and stay in EMIT.
- `load_ready` = IDLE || (EMIT && `m_last` && `m_ready`). This is the only combinational input-to-output path.
- `load` while `load_ready` = 0 is ignored: no capture and no error.
- The `mode` and `relu` values in effect are the captured ones. Changing these inputs mid-drain has no effect.
- Output values:
  - `m_valid` = (state == EMIT).
  - `m_last` = EMIT && `lane_cnt` == last lane.
  - `busy` = `m_valid`.
  - `m_data` and `m_lane` are driven to 0 when `m_valid` = 0.

## Timing
- Reset is asynchronous. It forces IDLE, `lane_cnt` = 0, capture registers = 0, `m_valid` = 0, `m_data` = 0, `m_lane` = 0, `m_last` = 0, `busy` = 0 and `load_ready` = 1. `load` is ignored while `reset` is high.
- Reset mid-EMIT aborts the word. Beats not yet accepted are dropped, and `m_valid` falls without waiting for a clock edge.
- Latency: a capture at edge N gives lane 0 on `m_data` with `m_valid` = 1 after edge N. Each subsequent lane follows the edge after its predecessor's handshake.
- Throughput with `m_ready` held at 1 and back-to-back loads: 2 cycles per word in mode 0, 4 in mode 1, with no bubble between words.
- While `m_valid && !m_ready`, `m_data`, `m_lane` and `m_last` must be held stable.
- All stream outputs are decoded from registered state and captured data only, with no dependency on `packed_i`.

## Structure
- Shared package `mac_pack_pkg`:
  - Width constants (`ACC_WIDTH_88`, `ACC_WIDTH_18`, `PACKED_WIDTH`).
  - Mode encoding (`MODE_88` = 0, `MODE_18` = 1).
  - Last-lane index per mode.
  - FSM state typedef.
  - These are shared with the MAC and PE array.
- One sub-module, `mac_lane_extract`: combinational lane select, sign extension and ReLU from (word, mode, relu, `lane_cnt`). The FSM, counter and capture registers stay in the top level.

## Test plan
- Mode 0, relu = 0, lane 0 = 0x000064 and lane 1 = 0xFFFF9C, `m_ready` = 1 → beats 0x000064 (`m_lane` 0) and 0xFFFF9C (`m_lane` 1, `m_last` = 1) on cycles N+1 and N+2, then IDLE.
- Mode 1, relu = 0, fields 0x7FFF, 0x8000, 0x0001, 0xFFFF → beats 0x007FFF, 0xFF8000, 0x000001, 0xFFFFFF, with `m_last` on lane 3 only.
- Same word as the previous scenario with relu = 1 → beats 0x007FFF, 0x000000, 0x000001, 0x000000.
- `m_ready` low for 3 cycles on lane 1, with `load` pulsed during the stall → lane 1 data held stable, `load_ready` = 0, no capture, drain completes with the original word.
- Mode-1 word followed by a mode-0 word, with `load` asserted in the cycle of lane 3's handshake → new lane 0 appears on the next cycle with no bubble, and `m_last` follows the new mode (lane 1).
- `reset` asserted mid-EMIT at lane 2 → `m_valid` and `busy` drop immediately. After release, a fresh mode-0 load drains correctly from lane 0.

Source files
------------

// File: rtl/mac_pack_pkg.sv
// Shared constants and types for the packed-lane MAC, PE array and result unpacker.
package mac_pack_pkg;

  localparam int unsigned ACC_WIDTH_88 = 24;
  localparam int unsigned ACC_WIDTH_18 = 16;
  localparam int unsigned PACKED_WIDTH = 64;
  localparam int unsigned OUT_WIDTH    = 24;

  localparam logic MODE_88 = 1'b0;
  localparam logic MODE_18 = 1'b1;

  localparam logic [1:0] LAST_LANE_88 = 2'd1;
  localparam logic [1:0] LAST_LANE_18 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index of the final lane of a word for the given mode.
  function automatic logic [1:0] last_lane(input logic mode);
    return (mode == MODE_18) ? LAST_LANE_18 : LAST_LANE_88;
  endfunction

endpackage

// File: rtl/mac_result_unpacker_if.sv
// Capture-side and drain-side signals of the MAC result unpacker.
//   load/mode/relu/packed_i/load_ready : word capture handshake
//   m_valid/m_ready/m_data/m_lane/m_last : per-lane output stream
//   busy : a captured word is still draining
// slave  = unpacker view, master = producer/consumer view.
interface mac_result_unpacker_if #(
  parameter int unsigned PACKED_WIDTH = mac_pack_pkg::PACKED_WIDTH,
  parameter int unsigned OUT_WIDTH    = mac_pack_pkg::OUT_WIDTH
);
  logic                    load;
  logic                    load_ready;
  logic                    mode;
  logic                    relu;
  logic [PACKED_WIDTH-1:0] packed_i;
  logic                    m_valid;
  logic                    m_ready;
  logic [OUT_WIDTH-1:0]    m_data;
  logic [1:0]              m_lane;
  logic                    m_last;
  logic                    busy;

  modport slave (
    input  load, mode, relu, packed_i, m_ready,
    output load_ready, m_valid, m_data, m_lane, m_last, busy
  );

  modport master (
    output load, mode, relu, packed_i, m_ready,
    input  load_ready, m_valid, m_data, m_lane, m_last, busy
  );
endinterface

// File: rtl/mac_lane_extract.sv
// Selects one lane of a captured packed word, sign-extends it and applies ReLU.
//   word/mode/relu/lane_cnt : captured word, lane layout, ReLU enable, lane index
//   data_c                  : signed lane value at OUT_WIDTH (combinational)
module mac_lane_extract
  import mac_pack_pkg::*;
#(
  parameter int unsigned ACC_WIDTH_88 = mac_pack_pkg::ACC_WIDTH_88,
  parameter int unsigned ACC_WIDTH_18 = mac_pack_pkg::ACC_WIDTH_18,
  parameter int unsigned PACKED_WIDTH = mac_pack_pkg::PACKED_WIDTH,
  parameter int unsigned OUT_WIDTH    = mac_pack_pkg::OUT_WIDTH
) (
  input  logic [PACKED_WIDTH-1:0] word,
  input  logic                    mode,
  input  logic                    relu,
  input  logic [1:0]              lane_cnt,
  output logic [OUT_WIDTH-1:0]    data_c
);

  logic [ACC_WIDTH_88-1:0] lane88;
  logic [ACC_WIDTH_18-1:0] lane18;
  logic [OUT_WIDTH-1:0]    ext;
  logic                    neg;

  // Lane select; in 8x8 mode the counter never exceeds 1, so only bit 0 matters.
  always_comb begin
    lane88 = lane_cnt[0] ? word[ACC_WIDTH_88 +: ACC_WIDTH_88] : word[0 +: ACC_WIDTH_88];
    case (lane_cnt)
      2'd0:    lane18 = word[0 +: ACC_WIDTH_18];
      2'd1:    lane18 = word[ACC_WIDTH_18 +: ACC_WIDTH_18];
      2'd2:    lane18 = word[2*ACC_WIDTH_18 +: ACC_WIDTH_18];
      default: lane18 = word[3*ACC_WIDTH_18 +: ACC_WIDTH_18];
    endcase
  end

  // Sign extension from the lane MSB, then ReLU clamps negatives to zero.
  always_comb begin
    if (mode == MODE_88) begin
      neg = lane88[ACC_WIDTH_88-1];
      ext = OUT_WIDTH'($signed(lane88));
    end else begin
      neg = lane18[ACC_WIDTH_18-1];
      ext = OUT_WIDTH'($signed(lane18));
    end
    data_c = (relu && neg) ? '0 : ext;
  end

endmodule

// File: rtl/mac_result_unpacker.sv
// Captures a packed accumulator word and drains its lanes one per beat.
//   clk, reset : clock, async active-high reset
//   bus        : capture handshake (load/load_ready/mode/relu/packed_i),
//                output stream (m_valid/m_ready/m_data/m_lane/m_last), busy
module mac_result_unpacker #(
  parameter int unsigned ACC_WIDTH_88 = mac_pack_pkg::ACC_WIDTH_88,
  parameter int unsigned ACC_WIDTH_18 = mac_pack_pkg::ACC_WIDTH_18,
  parameter int unsigned PACKED_WIDTH = mac_pack_pkg::PACKED_WIDTH,
  parameter int unsigned OUT_WIDTH    = mac_pack_pkg::OUT_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  mac_result_unpacker_if.slave  bus
);
  import mac_pack_pkg::*;

  state_t                  state;
  logic [PACKED_WIDTH-1:0] word_q;
  logic                    mode_q;
  logic                    relu_q;
  logic [1:0]              lane_cnt;

  logic                    emit;
  logic                    at_last;
  logic                    capture;
  logic [OUT_WIDTH-1:0]    lane_data_c;

  assign emit    = (state == EMIT);
  assign at_last = (lane_cnt == last_lane(mode_q));
  // A new word may be taken while the final lane is being accepted.
  assign capture = bus.load && bus.load_ready;

  // FSM, lane counter and capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_q   <= '0;
      mode_q   <= MODE_88;
      relu_q   <= 1'b0;
      lane_cnt <= 2'd0;
    end else if (capture) begin
      state    <= EMIT;
      word_q   <= bus.packed_i;
      mode_q   <= bus.mode;
      relu_q   <= bus.relu;
      lane_cnt <= 2'd0;
    end else if (emit && bus.m_ready) begin
      if (at_last) begin
        state    <= IDLE;
        lane_cnt <= 2'd0;
      end else begin
        lane_cnt <= lane_cnt + 2'd1;
      end
    end
  end

  mac_lane_extract #(
    .ACC_WIDTH_88 (ACC_WIDTH_88),
    .ACC_WIDTH_18 (ACC_WIDTH_18),
    .PACKED_WIDTH (PACKED_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_extract (
    .word     (word_q),
    .mode     (mode_q),
    .relu     (relu_q),
    .lane_cnt (lane_cnt),
    .data_c   (lane_data_c)
  );

  // Stream outputs decode only from registered state and captured data.
  assign bus.m_valid    = emit;
  assign bus.busy       = emit;
  assign bus.m_last     = emit && at_last;
  assign bus.m_lane     = emit ? lane_cnt : 2'd0;
  assign bus.m_data     = emit ? lane_data_c : '0;
  assign bus.load_ready = !emit || (at_last && bus.m_ready);

endmodule

// File: tb/tb_mac_result_unpacker.sv
// Directed bench for mac_result_unpacker.
module tb_mac_result_unpacker;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mac_result_unpacker_if #(.PACKED_WIDTH(64), .OUT_WIDTH(24)) bus ();

  mac_result_unpacker #(
    .ACC_WIDTH_88 (24),
    .ACC_WIDTH_18 (16),
    .PACKED_WIDTH (64),
    .OUT_WIDTH    (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic v, input logic [23:0] d,
                      input logic [1:0] l, input logic last);
    chk({tag, ".valid"}, 64'(bus.m_valid), 64'(v));
    chk({tag, ".busy"},  64'(bus.busy),    64'(v));
    chk({tag, ".data"},  64'(bus.m_data),  64'(d));
    chk({tag, ".lane"},  64'(bus.m_lane),  64'(l));
    chk({tag, ".last"},  64'(bus.m_last),  64'(last));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.mode    = 1'b0;
    bus.relu    = 1'b0;
    bus.packed_i = '0;
    bus.m_ready = 1'b1;
    tick();
    tick();
    beat("rst", 1'b0, 24'h0, 2'd0, 1'b0);
    chk("rst.load_ready", 64'(bus.load_ready), 64'd1);
    reset = 1'b0;
    tick();

    // Mode 0, relu off.
    bus.load = 1'b1; bus.mode = 1'b0; bus.relu = 1'b0;
    bus.packed_i = {16'hDEAD, 24'hFFFF9C, 24'h000064};
    tick();
    bus.load = 1'b0;
    beat("m0.l0", 1'b1, 24'h000064, 2'd0, 1'b0);
    chk("m0.l0.load_ready", 64'(bus.load_ready), 64'd0);
    tick();
    beat("m0.l1", 1'b1, 24'hFFFF9C, 2'd1, 1'b1);
    chk("m0.l1.load_ready", 64'(bus.load_ready), 64'd1);
    tick();
    beat("m0.idle", 1'b0, 24'h0, 2'd0, 1'b0);

    // Mode 1, relu off; mode/relu inputs flipped mid-drain must not matter.
    bus.load = 1'b1; bus.mode = 1'b1; bus.relu = 1'b0;
    bus.packed_i = {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF};
    tick();
    bus.load = 1'b0; bus.mode = 1'b0; bus.relu = 1'b1;
    beat("m1.l0", 1'b1, 24'h007FFF, 2'd0, 1'b0);
    tick();
    beat("m1.l1", 1'b1, 24'hFF8000, 2'd1, 1'b0);
    tick();
    beat("m1.l2", 1'b1, 24'h000001, 2'd2, 1'b0);
    tick();
    beat("m1.l3", 1'b1, 24'hFFFFFF, 2'd3, 1'b1);
    tick();
    beat("m1.idle", 1'b0, 24'h0, 2'd0, 1'b0);

    // Same word with relu on.
    bus.load = 1'b1; bus.mode = 1'b1; bus.relu = 1'b1;
    tick();
    bus.load = 1'b0; bus.relu = 1'b0;
    beat("relu.l0", 1'b1, 24'h007FFF, 2'd0, 1'b0);
    tick();
    beat("relu.l1", 1'b1, 24'h000000, 2'd1, 1'b0);
    tick();
    beat("relu.l2", 1'b1, 24'h000001, 2'd2, 1'b0);
    tick();
    beat("relu.l3", 1'b1, 24'h000000, 2'd3, 1'b1);
    tick();
    beat("relu.idle", 1'b0, 24'h0, 2'd0, 1'b0);

    // Stall on lane 1 with load pulsed; the pending word must not be replaced.
    bus.load = 1'b1; bus.mode = 1'b0; bus.relu = 1'b0;
    bus.packed_i = {16'h0, 24'hABCDEF, 24'h123456};
    tick();
    bus.load = 1'b0;
    beat("stall.l0", 1'b1, 24'h123456, 2'd0, 1'b0);
    tick();
    bus.m_ready = 1'b0;
    bus.load = 1'b1; bus.mode = 1'b1; bus.relu = 1'b1;
    bus.packed_i = 64'h1111_2222_3333_4444;
    #1;
    chk("stall.load_ready", 64'(bus.load_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      beat("stall.hold", 1'b1, 24'hABCDEF, 2'd1, 1'b1);
      chk("stall.hold.load_ready", 64'(bus.load_ready), 64'd0);
      tick();
    end
    bus.load = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    beat("stall.l1", 1'b1, 24'hABCDEF, 2'd1, 1'b1);
    chk("stall.release.load_ready", 64'(bus.load_ready), 64'd1);
    tick();
    beat("stall.idle", 1'b0, 24'h0, 2'd0, 1'b0);

    // Back-to-back: mode-1 word then mode-0 word loaded on lane 3's handshake.
    bus.load = 1'b1; bus.mode = 1'b1; bus.relu = 1'b0;
    bus.packed_i = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tick();
    bus.load = 1'b0;
    beat("b2b.a0", 1'b1, 24'h000001, 2'd0, 1'b0);
    tick();
    beat("b2b.a1", 1'b1, 24'h000002, 2'd1, 1'b0);
    tick();
    beat("b2b.a2", 1'b1, 24'h000003, 2'd2, 1'b0);
    tick();
    bus.load = 1'b1; bus.mode = 1'b0;
    bus.packed_i = {16'h0, 24'h800000, 24'h000005};
    #1;
    beat("b2b.a3", 1'b1, 24'h000004, 2'd3, 1'b1);
    chk("b2b.load_ready", 64'(bus.load_ready), 64'd1);
    tick();
    bus.load = 1'b0;
    beat("b2b.b0", 1'b1, 24'h000005, 2'd0, 1'b0);
    tick();
    beat("b2b.b1", 1'b1, 24'h800000, 2'd1, 1'b1);
    tick();
    beat("b2b.idle", 1'b0, 24'h0, 2'd0, 1'b0);

    // Reset mid-drain at lane 2 drops the word without a clock edge.
    bus.load = 1'b1; bus.mode = 1'b1;
    bus.packed_i = {16'h0D0D, 16'hC0C0, 16'h0B0B, 16'h0A0A};
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    beat("rst2.l2", 1'b1, 24'hFFC0C0, 2'd2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    beat("rst2.async", 1'b0, 24'h0, 2'd0, 1'b0);
    chk("rst2.load_ready", 64'(bus.load_ready), 64'd1);
    bus.load = 1'b1;
    tick();
    beat("rst2.held", 1'b0, 24'h0, 2'd0, 1'b0);
    bus.load = 1'b0;
    reset = 1'b0;
    tick();
    beat("rst2.post", 1'b0, 24'h0, 2'd0, 1'b0);
    bus.load = 1'b1; bus.mode = 1'b0; bus.relu = 1'b0;
    bus.packed_i = {16'hBEEF, 24'h000010, 24'hFFFFFF};
    tick();
    bus.load = 1'b0;
    beat("rst2.f0", 1'b1, 24'hFFFFFF, 2'd0, 1'b0);
    tick();
    beat("rst2.f1", 1'b1, 24'h000010, 2'd1, 1'b1);
    tick();
    beat("rst2.idle", 1'b0, 24'h0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
